l2_request_responder: RTL and testbench

- Next-level responder that services the line-address requests the L1 data and instruction caches emit on a miss, write or fill.
- Accepts 26-bit line addresses, each tagged read or write, through a valid/ready handshake into a small FIFO.
- Models fixed next-level access latency per request, then returns a completion through a second valid/ready handshake.
- Keeps read/write/request statistics for the statistics module.

---
 rtl/beefa55_mem_pkg.sv | 20 ++
 rtl/l2_req_fifo.sv | 59 +++++
 rtl/l2_request_responder.sv | 129 ++++++++++++
 tb/tb_l2_request_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/beefa55_mem_pkg.sv
// rtl/beefa55_mem_pkg.sv - shared memory-side types for the L1 caches and the L2 responder
//   LINE_ADDR_W : line address width (add_in[31:6])
//   l2_state_e  : responder FSM states
//   l2_req_t    : packed line request {addr, write}
package beefa55_mem_pkg;

  localparam int LINE_ADDR_W = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } l2_state_e;

  typedef struct packed {
    logic [LINE_ADDR_W-1:0] addr;
    logic                   write;
  } l2_req_t;

endpackage

// File: rtl/l2_req_fifo.sv
// rtl/l2_req_fifo.sv - request FIFO with registered head read
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din when not full (push while full is dropped)
//   pop, dout  : on pop (when not empty) the head is registered into dout
//   full/empty : derived from registered pointers only
module l2_req_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Extra MSB on each pointer tells a full FIFO apart from an empty one.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  assign dout    = dout_q;

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_pop) begin
        dout_q <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/l2_request_responder.sv
// rtl/l2_request_responder.sv - fixed-latency next-level responder for L1 line requests
//   clk, rst_n                      : clock, asynchronous active-low reset
//   req_valid/req_ready             : request handshake (req_ready = !full)
//   req_addr, req_write             : line address and type of request
//   resp_valid/resp_ready           : completion handshake
//   resp_addr, resp_write           : registered address/type of completed request
//   busy                            : FIFO non-empty or FSM not IDLE
//   read_count/write_count/req_count: wrapping statistics counters
module l2_request_responder
  import beefa55_mem_pkg::*;
#(
  parameter int ADDR_W  = LINE_ADDR_W,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 8,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_write,
  output logic              busy,
  output logic [CNT_W-1:0]  read_count,
  output logic [CNT_W-1:0]  write_count,
  output logic [CNT_W-1:0]  req_count
);

  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  l2_state_e        state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [ADDR_W:0]  fifo_dout;
  logic [CNT_W-1:0] read_count_q, write_count_q, req_count_q;

  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;
  assign pop       = (state_q == IDLE) && !fifo_empty;

  // The FIFO's registered head doubles as the current-request register:
  // it is loaded on the dequeue edge and holds until the next dequeue, so
  // resp_addr/resp_write stay stable through WAIT and RESP.
  l2_req_fifo #(
    .WIDTH (ADDR_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({req_addr, req_write}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = WAIT;
          cnt_d   = LAT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_valid = (state_q == RESP);
    busy       = !fifo_empty || (state_q != IDLE);
    resp_addr  = fifo_dout[ADDR_W:1];
    resp_write = fifo_dout[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_count_q  <= '0;
      write_count_q <= '0;
      req_count_q   <= '0;
    end else begin
      if (push) begin
        req_count_q <= req_count_q + CNT_W'(1);
      end
      if ((state_q == RESP) && resp_ready) begin
        if (fifo_dout[0]) begin
          write_count_q <= write_count_q + CNT_W'(1);
        end else begin
          read_count_q <= read_count_q + CNT_W'(1);
        end
      end
    end
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;
  assign req_count   = req_count_q;

endmodule

// File: tb/tb_l2_request_responder.sv
// tb/tb_l2_request_responder.sv - scoreboard bench for l2_request_responder
module tb_l2_request_responder;
  import beefa55_mem_pkg::*;

  localparam int LATENCY = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [25:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [25:0] resp_addr;
  logic        resp_write;
  logic        busy;
  logic [31:0] read_count, write_count, req_count;

  int tests = 0;
  int fails = 0;
  int exp_reads = 0;
  int exp_writes = 0;
  int exp_reqs = 0;
  l2_req_t exp_q[$];

  l2_request_responder #(
    .ADDR_W (26), .DEPTH (4), .LATENCY (LATENCY), .CNT_W (32)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_addr (req_addr), .req_write (req_write),
    .resp_valid (resp_valid), .resp_ready (resp_ready),
    .resp_addr (resp_addr), .resp_write (resp_write),
    .busy (busy),
    .read_count (read_count), .write_count (write_count), .req_count (req_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d fails=%0d)", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: the handshake completes on the posedge following this negedge.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got addr 0x%0h write %0b, expected none",
                 resp_addr, resp_write);
      end else begin
        l2_req_t e;
        e = exp_q.pop_front();
        check("resp_order", {5'd0, resp_addr, resp_write}, {5'd0, e.addr, e.write});
        if (e.write) exp_writes++;
        else exp_reads++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [25:0] a, input logic w);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back('{addr: a, write: w});
      exp_reqs++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_resp_valid();
    int n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("resp_valid_seen", resp_valid, 1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_read_count"}, read_count, exp_reads);
    check({tag, "_write_count"}, write_count, exp_writes);
    check({tag, "_req_count"}, req_count, exp_reqs);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_reads = 0; exp_writes = 0; exp_reqs = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int stale;

    // 1: reset then idle
    #2;
    check("t1_req_ready_in_reset", req_ready, 1);
    check("t1_busy_in_reset", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_counts("t1");
    check("t1_resp_valid", resp_valid, 0);
    check("t1_req_ready", req_ready, 1);
    check("t1_busy", busy, 0);
    check("t1_resp_addr", resp_addr, 0);

    // 2: single read, exact latency
    resp_ready = 1'b1;
    send(26'h0ABCDEF, 1'b0);
    for (int i = 1; i <= LATENCY + 1; i++) begin
      @(posedge clk); #1;
      if (i == LATENCY) check("t2_not_early", resp_valid, 0);
      if (i == LATENCY + 1) check("t2_on_time", resp_valid, 1);
    end
    drain();
    check("t2_read_count", read_count, 1);
    check("t2_req_count", req_count, 1);
    check("t2_write_count", write_count, 0);

    // 3: fill to full under backpressure
    resp_ready = 1'b0;
    send(26'h0000100, 1'b1);
    send(26'h0000200, 1'b0);
    send(26'h0000300, 1'b1);
    send(26'h0000400, 1'b0);
    check("t3_ready_before_last", req_ready, 1);
    send(26'h0000500, 1'b1);
    check("t3_full_ready_low", req_ready, 0);
    check("t3_busy", busy, 1);
    wait_resp_valid();
    repeat (3) @(posedge clk);
    #1;
    check("t3_resp_held", resp_addr, 26'h0000100);
    resp_ready = 1'b1;
    drain();
    check("t3_total", read_count + write_count, 6);
    check_counts("t3");
    check("t3_idle", busy, 0);

    // 4: mixed ordering from a clean reset
    do_reset();
    send(26'h1, 1'b1);
    send(26'h2, 1'b0);
    send(26'h3, 1'b1);
    drain();
    check("t4_read_count", read_count, 1);
    check("t4_write_count", write_count, 2);
    check("t4_req_count", req_count, 3);

    // 6: push on the same edge IDLE dequeues, occupancy 1
    resp_ready = 1'b0;
    send(26'h0000A0, 1'b0);
    send(26'h0000B0, 1'b1);
    wait_resp_valid();
    resp_ready = 1'b1;
    @(posedge clk); #1;        // A handshakes, FSM back in IDLE with B queued
    req_valid = 1'b1;
    req_addr  = 26'h0000C0;
    req_write = 1'b0;
    check("t6_ready_before", req_ready, 1);
    exp_q.push_back('{addr: 26'h0000C0, write: 1'b0});
    exp_reqs++;
    @(posedge clk); #1;        // B popped, C pushed
    req_valid = 1'b0;
    check("t6_ready_after", req_ready, 1);
    check("t6_busy", busy, 1);
    send(26'h0000D0, 1'b1);
    send(26'h0000E0, 1'b0);
    check("t6_occ3_ready", req_ready, 1);
    send(26'h0000F0, 1'b1);
    check("t6_occ4_full", req_ready, 0);
    drain();
    check_counts("t6");

    // 5: reset during WAIT with two queued entries
    resp_ready = 1'b1;
    send(26'h0000111, 1'b0);
    send(26'h0000222, 1'b1);
    send(26'h0000333, 1'b0);
    check("t5_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_resp_valid_in_reset", resp_valid, 0);
    check("t5_busy_in_reset", busy, 0);
    check("t5_ready_in_reset", req_ready, 1);
    exp_q.delete();
    exp_reads = 0; exp_writes = 0; exp_reqs = 0;
    check_counts("t5_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_busy_after", busy, 0);
    stale = 0;
    for (int i = 0; i < 2 * (LATENCY + 2); i++) begin
      @(posedge clk); #1;
      if (resp_valid || busy) stale++;
    end
    check("t5_no_stale", stale, 0);
    check_counts("t5_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
